// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller. Drives trial values into a
// magnitude comparator's B side, reads back Lesser/Greater/Equal and walks the
// operand MSB-first until it has recovered the comparator's hidden A value.
module sar_search_ctrl #(
  parameter int unsigned WIDTH = 4,
  localparam int unsigned CW = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] trial,
  input  logic             Lesser,
  input  logic             Greater,
  input  logic             Equal,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic [CW-1:0]    steps
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StTry  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [WIDTH-1:0] One = WIDTH'(1);
  localparam logic [WIDTH-1:0] Msb = One << (WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic [CW-1:0]    steps_q, steps_d;

  logic [2:0]       code;
  logic [WIDTH-1:0] acc_new;
  logic             term;

  assign code = {Lesser, Greater, Equal};

  // Next-state: one comparator decision per cycle while in StTry.
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    acc_d    = acc_q;
    trial_d  = trial_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    err_d    = err_q;
    steps_d  = steps_q;
    acc_new  = acc_q;
    term     = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StTry;
          bit_d   = CW'(WIDTH - 1);
          acc_d   = '0;
          trial_d = Msb;
          busy_d  = 1'b1;
          steps_d = '0;
          err_d   = 1'b0;
        end
      end

      StTry: begin
        steps_d = steps_q + 1'b1;
        case (code)
          3'b001: begin
            result_d = trial_q;
            term     = 1'b1;
          end
          3'b010: acc_new = trial_q;  // A above trial: keep the bit
          3'b100: acc_new = acc_q;    // A below trial: drop the bit
          default: begin
            // Not one-hot: comparator is broken, report what we have so far.
            err_d    = 1'b1;
            result_d = acc_q;
            term     = 1'b1;
          end
        endcase

        if (!term) begin
          if (bit_q == '0) begin
            result_d = acc_new;
            term     = 1'b1;
          end else begin
            bit_d   = bit_q - 1'b1;
            trial_d = acc_new | (One << (bit_q - 1'b1));
          end
        end
        acc_d = acc_new;

        if (term) begin
          state_d = StDone;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          trial_d = '0;
        end
      end

      StDone: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      bit_q    <= '0;
      acc_q    <= '0;
      trial_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
      steps_q  <= '0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      acc_q    <= acc_d;
      trial_q  <= trial_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      err_q    <= err_d;
      steps_q  <= steps_d;
    end
  end

  assign trial  = trial_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;
  assign steps  = steps_q;

endmodule

// File: doc/sar_search_ctrl.md
Name: sar_search_ctrl

Overview:
- Successive-approximation search controller: the initiator side of the magnitude-comparator interface.
- The comparator (responder) compares a hidden operand A against the trial value this block drives on its B side. Its outputs are Lesser, Greater and Equal.
- The block binary-searches MSB-first to recover A in at most WIDTH compare cycles, then reports the result with a done pulse.
- It sits beside the comparator slice and is used both for value recovery and for comparator self-check.

Parameters:
- WIDTH, 4, operand width; also the maximum number of compare cycles.
- CW, $clog2(WIDTH)+1, width of the step counter (local, derived).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- start  input  1  request a search; honoured only in IDLE.
- trial  output  WIDTH  registered value driven to the comparator's B input.
- Lesser  input  1  comparator: A < trial.
- Greater  input  1  comparator: A > trial.
- Equal  input  1  comparator: A == trial.
- busy  output  1  high while in TRY.
- done  output  1  one-cycle pulse when the search ends.
- result  output  WIDTH  recovered A; valid from done until the next accepted start.
- err  output  1  comparator returned an illegal code; valid with done.
- steps  output  CW  number of compare cycles used; valid with done.

Behaviour:
- Synchronous active-low reset: one clock; reset sampled only on rising edge of clk.
- Reset values: trial=0, busy=0, done=0, result=0, err=0, steps=0, state=IDLE. Reset mid-search aborts immediately; no done pulse is issued.
- Comparator path is combinational: Lesser/Greater/Equal are sampled in the same cycle trial is presented.
- IDLE:
  - start=1 → TRY at next edge with bit=WIDTH-1, acc=0, trial=1<<(WIDTH-1), busy=1, steps=0, err=0.
  - start=0 → stay; result, err and steps hold their last values.
- TRY, one compare per cycle; steps increments by 1 at each TRY edge. Decode the compare code {Lesser,Greater,Equal}:
  - Code not one-hot (000, 011, 101, 110, 111): → DONE, err=1, result=acc.
  - Equal: → DONE, result=trial (early termination).
  - Greater: acc keeps the trial bit (acc=trial).
  - Lesser: acc unchanged, so the trial bit is cleared.
  - If not terminated and bit==0: → DONE, result=acc after this cycle's update.
  - Otherwise: bit decrements and trial = acc_new | (1<<(bit-1)).
- DONE: done=1 and busy=0 for exactly one cycle, trial=0, then → IDLE.
- start held high or pulsed during TRY or DONE is ignored. start high in the cycle after DONE (state IDLE) launches a new search.
- Latency: start-accepted edge → WIDTH compare cycles worst case → done. Fewer cycles when Equal hits early. Minimum is 1 compare cycle (A=1<<(WIDTH-1)).
- Outcome: for a legal comparator, result==A for every A in [0, 2^WIDTH-1]. A=0 never produces Equal; it resolves by exhaustion with result=0.
- Arithmetic: all trial/acc operations are bitwise OR on WIDTH bits; no overflow possible.

Test Plan (WIDTH=4; bench holds A and models the comparator behaviourally with the same Lesser/Greater/Equal semantics):
- A=5, start pulse → trials 8,4,6,5 on successive cycles; done with result=5, steps=4, err=0.
- A=8 → single trial 8 (Equal); done on the following cycle with result=8, steps=1.
- A=0 → trials 8,4,2,1, all Lesser; result=0, steps=4, err=0. A=15 → trials 8,12,14,15; result=15, steps=4.
- Exhaustive sweep A=0..15 with back-to-back starts issued the cycle after each done → result==A every time, steps≤4, err never set.
- Comparator forced to Lesser=1,Greater=1 on the 2nd trial (A=5) → done after 2 cycles with err=1, result=0. Start pulses during busy are ignored (trial sequence unchanged).
- rst_n=0 for one edge during the 3rd trial → all outputs 0, no done pulse. A new start then completes normally with result=A.
